jk_excitation_driver: RTL and testbench

//  Drives a WIDTH-bit bank of external JK flip-flops (FFJK instances) to a requested target state.
//  Per-bit J/K values come from the JK excitation table, then Q feedback is checked against the target.

---
 rtl/jk_excitation_driver.sv | 98 +++++++++
 tb/tb_jk_excitation_driver.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_excitation_driver.sv
// Drives a bank of external JK flip-flops toward a target state, then checks the Q feedback.
// Latency: 3 cycles per target (accept, apply, check). Backpressure: tgt_ready is high only while idle.
module jk_excitation_driver #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tgt_valid,
  output logic                 tgt_ready,
  input  logic [WIDTH-1:0]     tgt_data,
  input  logic [WIDTH-1:0]     q_fb,
  output logic [WIDTH-1:0]     j_out,
  output logic [WIDTH-1:0]     k_out,
  input  logic                 err_clr,
  output logic                 done_pulse,
  output logic                 match,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2
  } state_e;

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  state_e               state_q;
  logic [WIDTH-1:0]     tgt_q;
  logic [WIDTH-1:0]     j_q;
  logic [WIDTH-1:0]     k_q;
  logic                 done_q;
  logic                 match_q;
  logic [ERR_CNT_W-1:0] err_q;
  logic [ERR_CNT_W-1:0] err_d;

  // Clear has priority over a coincident mismatch; the count saturates instead of wrapping.
  always_comb begin
    err_d = err_q;
    if (err_clr) begin
      err_d = '0;
    end else if (state_q == CHECK && q_fb != tgt_q && err_q != ERR_MAX) begin
      err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      err_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= err_d;
      case (state_q)
        IDLE: begin
          j_q <= '0;
          k_q <= '0;
          if (tgt_valid) begin
            // Excitation table: J sets bits that must rise, K clears bits that must fall.
            tgt_q   <= tgt_data;
            j_q     <= tgt_data & ~q_fb;
            k_q     <= ~tgt_data & q_fb;
            state_q <= APPLY;
          end
        end
        APPLY: begin
          j_q     <= '0;
          k_q     <= '0;
          state_q <= CHECK;
        end
        CHECK: begin
          match_q <= (q_fb == tgt_q);
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          j_q     <= '0;
          k_q     <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tgt_ready  = (state_q == IDLE);
  assign j_out      = j_q;
  assign k_out      = k_q;
  assign done_pulse = done_q;
  assign match      = match_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: behavioural JK bank on the J/K outputs, vector table plus corner sequences.
module tb_jk_excitation_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tgt_valid;
  logic       tgt_ready;
  logic [3:0] tgt_data;
  logic [3:0] q_fb;
  logic [3:0] j_out;
  logic [3:0] k_out;
  logic       err_clr;
  logic       done_pulse;
  logic       match;
  logic [7:0] err_count;

  logic       bank_ld;
  logic [3:0] bank_val;
  logic [3:0] bank;
  logic       force_en;
  logic [3:0] force_val;

  int n_vec  = 0;
  int n_fail = 0;
  int err_exp = 0;

  always #5 clk = ~clk;

  // Behavioural FFJK bank on the same clock edge as the DUT.
  always @(posedge clk) begin
    if (bank_ld) bank <= bank_val;
    else         bank <= (j_out & ~bank) | (~k_out & bank);
  end

  assign q_fb = force_en ? force_val : bank;

  jk_excitation_driver #(.WIDTH(4), .ERR_CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tgt_valid  (tgt_valid),
    .tgt_ready  (tgt_ready),
    .tgt_data   (tgt_data),
    .q_fb       (q_fb),
    .j_out      (j_out),
    .k_out      (k_out),
    .err_clr    (err_clr),
    .done_pulse (done_pulse),
    .match      (match),
    .err_count  (err_count)
  );

  typedef struct {
    logic [3:0] q;
    logic       frc;
    logic [3:0] tgt;
    logic [3:0] exp_j;
    logic [3:0] exp_k;
    logic       exp_match;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_check_result(input logic mism, input logic clr);
    if (clr) err_exp = 0;
    else if (mism && err_exp < 255) err_exp++;
  endtask

  task automatic load_bank(input logic [3:0] v);
    bank_ld  = 1'b1;
    bank_val = v;
    tick();
    bank_ld  = 1'b0;
  endtask

  // Unchecked transaction used for bulk counting; updates the error model.
  task automatic do_txn(input logic [3:0] t, input logic exp_mism);
    tgt_valid = 1'b1;
    tgt_data  = t;
    tick();
    tgt_valid = 1'b0;
    tick();
    tick();
    model_check_result(exp_mism, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b1;
    tgt_valid = 1'b0;
    tgt_data  = 4'h0;
    err_clr   = 1'b0;
    bank_ld   = 1'b0;
    bank_val  = 4'h0;
    force_en  = 1'b0;
    force_val = 4'h0;

    //           q      frc   tgt     j       k       match
    vecs[0] = '{4'b0000, 1'b0, 4'b1010, 4'b1010, 4'b0000, 1'b1};
    vecs[1] = '{4'b1010, 1'b0, 4'b0110, 4'b0100, 4'b1000, 1'b1};
    vecs[2] = '{4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b1111, 1'b1};
    vecs[3] = '{4'b0011, 1'b0, 4'b0101, 4'b0100, 4'b0010, 1'b1};
    vecs[4] = '{4'b0000, 1'b1, 4'b1111, 4'b1111, 4'b0000, 1'b0};
    vecs[5] = '{4'b1111, 1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b0};

    // Asynchronous reset asserted mid-cycle.
    #3 rst_n = 1'b0;
    #1;
    chk("rst_j", j_out, 4'h0);
    chk("rst_k", k_out, 4'h0);
    chk("rst_match", match, 1'b0);
    chk("rst_err", err_count, 8'd0);
    chk("rst_done", done_pulse, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    load_bank(4'h0);
    chk("rst_ready", tgt_ready, 1'b1);

    foreach (vecs[i]) begin
      force_en  = vecs[i].frc;
      force_val = vecs[i].q;
      load_bank(vecs[i].q);
      tgt_valid = 1'b1;
      tgt_data  = vecs[i].tgt;
      tick();
      chk($sformatf("v%0d_j", i), j_out, vecs[i].exp_j);
      chk($sformatf("v%0d_k", i), k_out, vecs[i].exp_k);
      chk($sformatf("v%0d_rdy_apply", i), tgt_ready, 1'b0);
      tgt_valid = 1'b0;
      tgt_data  = ~vecs[i].tgt;
      tick();
      chk($sformatf("v%0d_j_idle", i), j_out, 4'h0);
      chk($sformatf("v%0d_k_idle", i), k_out, 4'h0);
      chk($sformatf("v%0d_done_early", i), done_pulse, 1'b0);
      tick();
      model_check_result(!vecs[i].exp_match, 1'b0);
      chk($sformatf("v%0d_done", i), done_pulse, 1'b1);
      chk($sformatf("v%0d_match", i), match, vecs[i].exp_match);
      chk($sformatf("v%0d_err", i), err_count, err_exp);
      tick();
      chk($sformatf("v%0d_done_off", i), done_pulse, 1'b0);
      chk($sformatf("v%0d_match_hold", i), match, vecs[i].exp_match);
      chk($sformatf("v%0d_rdy_idle", i), tgt_ready, 1'b1);
    end

    // Back-to-back: valid held high, next target accepted exactly 3 edges later.
    force_en  = 1'b0;
    load_bank(4'b1010);
    tgt_valid = 1'b1;
    tgt_data  = 4'b0110;
    tick();
    chk("b2b_j0", j_out, 4'b0100);
    chk("b2b_k0", k_out, 4'b1000);
    tgt_data = 4'b1111;
    tick();
    chk("b2b_rdy_e1", tgt_ready, 1'b0);
    tick();
    chk("b2b_done", done_pulse, 1'b1);
    chk("b2b_match_frozen_tgt", match, 1'b1);
    chk("b2b_rdy_e2", tgt_ready, 1'b1);
    tgt_data = 4'b1001;
    tick();
    chk("b2b_rdy_e3", tgt_ready, 1'b0);
    chk("b2b_j1", j_out, 4'b1001);
    chk("b2b_k1", k_out, 4'b0110);
    tgt_valid = 1'b0;
    tick();
    tick();
    chk("b2b_match2", match, 1'b1);
    tick();

    // Saturation of the mismatch counter.
    force_en  = 1'b1;
    force_val = 4'b0000;
    for (int n = 0; n < 300; n++) do_txn(4'b1111, 1'b1);
    chk("sat_err", err_count, err_exp);
    chk("sat_err_max", err_count, 8'd255);
    do_txn(4'b1111, 1'b1);
    chk("sat_hold", err_count, err_exp);

    // Clear coinciding with a mismatching check.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    model_check_result(1'b0, 1'b1);
    chk("clr_err", err_count, err_exp);
    for (int n = 0; n < 7; n++) do_txn(4'b1111, 1'b1);
    chk("clr_err7", err_count, 8'd7);
    tgt_valid = 1'b1;
    tgt_data  = 4'b1111;
    tick();
    tgt_valid = 1'b0;
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    model_check_result(1'b1, 1'b1);
    chk("clr_win_err", err_count, err_exp);
    chk("clr_win_match", match, 1'b0);
    chk("clr_win_done", done_pulse, 1'b1);
    tick();

    // Reset pulsed during APPLY.
    force_en = 1'b0;
    load_bank(4'b0000);
    tgt_valid = 1'b1;
    tgt_data  = 4'b1111;
    tick();
    tgt_valid = 1'b0;
    chk("mid_rst_j_before", j_out, 4'b1111);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_j", j_out, 4'h0);
    chk("mid_rst_k", k_out, 4'h0);
    tick();
    #2 rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk($sformatf("mid_rst_nodone%0d", n), done_pulse, 1'b0);
    end
    chk("mid_rst_err", err_count, 8'd0);
    chk("mid_rst_ready", tgt_ready, 1'b1);
    chk("mid_rst_bank_held", q_fb, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
